// File: rtl/reg_wb_scheduler_if.sv
// Decode, ALU/load writeback and register-file write-port signals of reg_wb_scheduler.
// The slave modport is the scheduler side; master is the decode/writeback/regfile side.
interface reg_wb_scheduler_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              issue_stall;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              REG_write_1;
    logic [ADDR_W-1:0] REG_address_wr;
    logic [DATA_W-1:0] REG_data_wb_in1;
    logic [ADDR_W:0]   busy_count;
    logic              wb_error;

    modport slave (
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output rs1_busy, rs2_busy, issue_stall, alu_ready, mem_ready,
        output REG_write_1, REG_address_wr, REG_data_wb_in1, busy_count, wb_error
    );

    modport master (
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  rs1_busy, rs2_busy, issue_stall, alu_ready, mem_ready,
        input  REG_write_1, REG_address_wr, REG_data_wb_in1, busy_count, wb_error
    );
endinterface

// File: rtl/reg_wb_scheduler.sv
// Round-robin share of the regfile write port between ALU and load writeback, plus busy scoreboard.
// Latency: a granted transfer appears on the write port one cycle later (registered).
// Backpressure: ready is the combinational grant; decode is held by combinational issue_stall.
module reg_wb_scheduler #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic               clk,
    input  logic               rst,
    reg_wb_scheduler_if.slave  bus
);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    src_e              last_grant;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic              alu_gnt;
    logic              mem_gnt;
    logic              xfer;
    logic [ADDR_W-1:0] xfer_rd;
    logic [DATA_W-1:0] xfer_data;
    logic              stall;
    logic              set_en;
    logic              clr_req;
    logic              clr_eff;
    logic              clr_err;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (!rst) begin
            if (bus.alu_valid && bus.mem_valid) begin
                alu_gnt = (last_grant == SRC_MEM);
                mem_gnt = (last_grant == SRC_ALU);
            end else begin
                alu_gnt = bus.alu_valid;
                mem_gnt = bus.mem_valid;
            end
        end
    end

    assign xfer      = alu_gnt || mem_gnt;
    assign xfer_rd   = mem_gnt ? bus.mem_rd   : bus.alu_rd;
    assign xfer_data = mem_gnt ? bus.mem_data : bus.alu_data;

    // No bypass: the regfile forwards its own write in the following cycle.
    assign stall = rst || (bus.issue_valid &&
                   (busy[bus.rs1_addr] || busy[bus.rs2_addr] ||
                    ((bus.issue_rd != '0) && busy[bus.issue_rd])));

    assign set_en  = bus.issue_valid && !stall && (bus.issue_rd != '0);
    assign clr_req = xfer && (xfer_rd != '0);
    assign clr_err = clr_req && !busy[xfer_rd];
    assign clr_eff = clr_req && busy[xfer_rd] && !(set_en && (bus.issue_rd == xfer_rd));

    always_comb begin
        busy_nxt = busy;
        if (clr_eff) busy_nxt[xfer_rd] = 1'b0;
        if (set_en)  busy_nxt[bus.issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            last_grant <= SRC_MEM;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            busy <= busy_nxt;
            wr_q <= clr_req;
            if (clr_req) begin
                addr_q <= xfer_rd;
                data_q <= xfer_data;
            end
            if (xfer) last_grant <= mem_gnt ? SRC_MEM : SRC_ALU;
            if (clr_err) err_q <= 1'b1;
            case ({set_en, clr_eff})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign bus.alu_ready       = alu_gnt;
    assign bus.mem_ready       = mem_gnt;
    assign bus.rs1_busy        = busy[bus.rs1_addr];
    assign bus.rs2_busy        = busy[bus.rs2_addr];
    assign bus.issue_stall     = stall;
    assign bus.REG_write_1     = wr_q;
    assign bus.REG_address_wr  = addr_q;
    assign bus.REG_data_wb_in1 = data_q;
    assign bus.busy_count      = cnt_q;
    assign bus.wb_error        = err_q;
endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Directed bench: expected register-file writes are queued by the stimulus and
// popped by an independent write-port monitor; combinational outputs are checked inline.
module tb_reg_wb_scheduler;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   done;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    reg_wb_scheduler_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    reg_wb_scheduler #(.ADDR_W(5), .DATA_W(32), .NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.alu_valid   = 1'b0;
        bus.mem_valid   = 1'b0;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Write-port monitor
    always @(negedge clk) begin
        if (!done && bus.REG_write_1 === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got write addr %0d data 0x%0h, expected no write",
                         bus.REG_address_wr, bus.REG_data_wb_in1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.REG_address_wr), 32'(e.rd));
                chk("wr_data", bus.REG_data_wb_in1, e.data);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        done   = 1'b0;
        rst    = 1'b1;
        bus.issue_rd = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;
        bus.alu_rd = '0; bus.alu_data = '0; bus.mem_rd = '0; bus.mem_data = '0;
        idle();

        // Reset: readys low and stall high regardless of requests
        cyc();
        bus.alu_valid = 1'b1; bus.mem_valid = 1'b1; bus.issue_valid = 1'b1;
        @(negedge clk);
        chk("rst_alu_ready", 32'(bus.alu_ready), 0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 0);
        chk("rst_stall", 32'(bus.issue_stall), 1);
        cyc();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_wr", 32'(bus.REG_write_1), 0);
        chk("rst_addr", 32'(bus.REG_address_wr), 0);
        chk("rst_data", bus.REG_data_wb_in1, 0);
        chk("rst_count", 32'(bus.busy_count), 0);
        chk("rst_err", 32'(bus.wb_error), 0);

        // Single ALU writeback to a busy register 5
        cyc();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
        @(negedge clk);
        chk("t1_stall", 32'(bus.issue_stall), 0);
        cyc();
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        push(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_alu_ready", 32'(bus.alu_ready), 1);
        chk("t1_mem_ready", 32'(bus.mem_ready), 0);
        chk("t1_count_set", 32'(bus.busy_count), 1);
        cyc();
        bus.alu_valid = 1'b0;
        @(negedge clk);
        chk("t1_wr_high", 32'(bus.REG_write_1), 1);
        chk("t1_count_clr", 32'(bus.busy_count), 0);
        chk("t1_err", 32'(bus.wb_error), 0);
        cyc();
        @(negedge clk);
        chk("t1_wr_low", 32'(bus.REG_write_1), 0);

        // Load writeback to x0: handshake only, no write, no error
        cyc();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h5555_5555;
        @(negedge clk);
        chk("x0_mem_ready", 32'(bus.mem_ready), 1);
        chk("x0_alu_ready", 32'(bus.alu_ready), 0);

        // Both valid continuously: ALU, MEM, ALU, MEM
        cyc();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1111_1111;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd2; bus.mem_data = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_alu_ready", 32'(bus.alu_ready), (i % 2 == 0) ? 1 : 0);
            chk("rr_mem_ready", 32'(bus.mem_ready), (i % 2 == 0) ? 0 : 1);
            if (i % 2 == 0) push(5'd1, 32'h1111_1111);
            else            push(5'd2, 32'h2222_2222);
            cyc();
        end
        idle();
        @(negedge clk);
        chk("rr_err_nonbusy", 32'(bus.wb_error), 1);
        chk("rr_count", 32'(bus.busy_count), 0);

        // RAW stall on rd=7 until the load writeback edge
        cyc();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        @(negedge clk);
        chk("raw_first_stall", 32'(bus.issue_stall), 0);
        cyc();
        bus.issue_rd = 5'd10; bus.rs1_addr = 5'd7;
        @(negedge clk);
        chk("raw_rs1_busy", 32'(bus.rs1_busy), 1);
        chk("raw_stall", 32'(bus.issue_stall), 1);
        chk("raw_count", 32'(bus.busy_count), 1);
        cyc();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h0000_0077;
        push(5'd7, 32'h0000_0077);
        @(negedge clk);
        chk("raw_mem_ready", 32'(bus.mem_ready), 1);
        chk("raw_stall_hold", 32'(bus.issue_stall), 1);
        cyc();
        bus.mem_valid = 1'b0;
        @(negedge clk);
        chk("raw_rs1_free", 32'(bus.rs1_busy), 0);
        chk("raw_release", 32'(bus.issue_stall), 0);
        chk("raw_count_clr", 32'(bus.busy_count), 0);
        cyc();
        bus.issue_valid = 1'b0; bus.rs1_addr = 5'd0;
        @(negedge clk);
        chk("raw_issue10", 32'(bus.busy_count), 1);

        // WAW: issue rd=9 while ALU writes back 9 on the same edge
        cyc();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        @(negedge clk);
        chk("waw_first", 32'(bus.issue_stall), 0);
        cyc();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h0000_0099;
        push(5'd9, 32'h0000_0099);
        @(negedge clk);
        chk("waw_stall", 32'(bus.issue_stall), 1);
        chk("waw_alu_ready", 32'(bus.alu_ready), 1);
        chk("waw_count", 32'(bus.busy_count), 2);
        cyc();
        idle(); bus.rs1_addr = 5'd9;
        @(negedge clk);
        chk("waw_count_after", 32'(bus.busy_count), 1);
        chk("waw_rs1_free", 32'(bus.rs1_busy), 0);

        // Set of 3 and clear of 4 on one edge
        cyc();
        bus.rs1_addr = 5'd0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
        @(negedge clk);
        chk("sc_issue4", 32'(bus.issue_stall), 0);
        cyc();
        bus.issue_rd = 5'd3;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h0000_0044;
        push(5'd4, 32'h0000_0044);
        @(negedge clk);
        chk("sc_stall", 32'(bus.issue_stall), 0);
        chk("sc_alu_ready", 32'(bus.alu_ready), 1);
        chk("sc_count_before", 32'(bus.busy_count), 2);
        cyc();
        idle(); bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd4;
        @(negedge clk);
        chk("sc_count_after", 32'(bus.busy_count), 2);
        chk("sc_rs1_busy3", 32'(bus.rs1_busy), 1);
        chk("sc_rs2_busy4", 32'(bus.rs2_busy), 0);

        // ALU writeback to x0 and issue to x0
        cyc();
        bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h0000_ABCD;
        @(negedge clk);
        chk("x0_alu_ready", 32'(bus.alu_ready), 1);
        cyc();
        bus.alu_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        @(negedge clk);
        chk("x0_issue_stall", 32'(bus.issue_stall), 0);
        chk("x0_rs1_busy", 32'(bus.rs1_busy), 0);
        cyc();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        chk("x0_count", 32'(bus.busy_count), 2);
        chk("err_sticky", 32'(bus.wb_error), 1);

        // Reset mid-stream with both sources valid
        cyc();
        rst = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3;  bus.alu_data = 32'h0000_0033;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd10; bus.mem_data = 32'h0000_00AA;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd11;
        @(negedge clk);
        chk("mrst_alu_ready", 32'(bus.alu_ready), 0);
        chk("mrst_mem_ready", 32'(bus.mem_ready), 0);
        chk("mrst_stall", 32'(bus.issue_stall), 1);
        cyc();
        rst = 1'b0;
        bus.issue_valid = 1'b0;
        push(5'd3, 32'h0000_0033);
        @(negedge clk);
        chk("mrst_wr", 32'(bus.REG_write_1), 0);
        chk("mrst_addr", 32'(bus.REG_address_wr), 0);
        chk("mrst_data", bus.REG_data_wb_in1, 0);
        chk("mrst_count", 32'(bus.busy_count), 0);
        chk("mrst_err", 32'(bus.wb_error), 0);
        chk("mrst_tie_alu", 32'(bus.alu_ready), 1);
        chk("mrst_tie_mem", 32'(bus.mem_ready), 0);
        cyc();
        bus.alu_valid = 1'b0;
        push(5'd10, 32'h0000_00AA);
        @(negedge clk);
        chk("mrst_mem_next", 32'(bus.mem_ready), 1);
        chk("mrst_err_set", 32'(bus.wb_error), 1);

        // Writeback to non-busy register 12 keeps the error sticky
        cyc();
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'h0000_C0C0;
        push(5'd12, 32'h0000_C0C0);
        @(negedge clk);
        chk("e12_alu_ready", 32'(bus.alu_ready), 1);
        cyc();
        idle();
        @(negedge clk);
        chk("e12_err", 32'(bus.wb_error), 1);
        chk("e12_count", 32'(bus.busy_count), 0);

        cyc();
        cyc();
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
